// File: rtl/decoder_select_arbiter_if.sv
// Request/grant bundle between the requesters and the select-bus arbiter.
// The master side drives enable and requests; the slave side (the arbiter) returns grants.
interface decoder_select_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt_n;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       preempt;

    modport master (
        output en, req,
        input  gnt_n, gnt_idx, busy, preempt
    );

    modport slave (
        input  en, req,
        output gnt_n, gnt_idx, busy, preempt
    );
endinterface

// File: rtl/decoder_select_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoded select bus, with hold-time limiting
// and a mandatory idle cycle between any two grants.
module decoder_select_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    decoder_select_arbiter_if.slave       bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     r_state;
    state_t     w_stateNxt;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;
    logic [7:0] r_gntN;
    logic [2:0] r_gntIdx;
    logic       r_busy;
    logic       r_preempt;

    logic [2:0] w_ptrNxt;
    logic [7:0] w_cntNxt;
    logic [7:0] w_gntNNxt;
    logic [2:0] w_gntIdxNxt;
    logic       w_busyNxt;
    logic       w_preemptNxt;

    logic [7:0] w_rot;
    logic [2:0] w_offset;
    logic [2:0] w_winner;
    logic       w_arbitrate;
    logic       w_ownerReq;
    logic       w_holdHit;
    logic       w_exit;

    // Requests rotated so bit 0 is the current highest-priority index.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < 8; i++) begin
            w_rot[i] = bus.req[r_ptr + 3'(i)];
        end
    end

    always_comb begin
        w_offset = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = 3'(i);
            end
        end
    end

    assign w_winner    = r_ptr + w_offset;
    assign w_arbitrate = bus.en && (bus.req != 8'h00);
    assign w_ownerReq  = bus.req[r_gntIdx];
    assign w_holdHit   = (r_cnt == 8'(HOLD_MAX));
    assign w_exit      = !bus.en || !w_ownerReq || w_holdHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_gntN    <= 8'hFF;
            r_gntIdx  <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_stateNxt;
            r_ptr     <= w_ptrNxt;
            r_cnt     <= w_cntNxt;
            r_gntN    <= w_gntNNxt;
            r_gntIdx  <= w_gntIdxNxt;
            r_busy    <= w_busyNxt;
            r_preempt <= w_preemptNxt;
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        case (r_state)
            IDLE:    if (w_arbitrate) w_stateNxt = GRANT;
            GRANT:   if (w_exit)      w_stateNxt = IDLE;
            default: w_stateNxt = IDLE;
        endcase
    end

    // Release always passes through IDLE, which gives the break-before-make gap.
    always_comb begin
        w_ptrNxt     = r_ptr;
        w_cntNxt     = r_cnt;
        w_gntNNxt    = r_gntN;
        w_gntIdxNxt  = r_gntIdx;
        w_busyNxt    = r_busy;
        w_preemptNxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arbitrate) begin
                    w_gntNNxt   = ~(8'd1 << w_winner);
                    w_gntIdxNxt = w_winner;
                    w_busyNxt   = 1'b1;
                    w_cntNxt    = 8'd1;
                    w_ptrNxt    = w_winner + 3'd1;
                end
            end
            GRANT: begin
                if (w_exit) begin
                    w_gntNNxt    = 8'hFF;
                    w_busyNxt    = 1'b0;
                    w_preemptNxt = bus.en && w_ownerReq && w_holdHit;
                end else begin
                    w_cntNxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_gntNNxt = 8'hFF;
                w_busyNxt = 1'b0;
            end
        endcase
    end

    assign bus.gnt_n   = r_gntN;
    assign bus.gnt_idx = r_gntIdx;
    assign bus.busy    = r_busy;
    assign bus.preempt = r_preempt;

endmodule
